// File: rtl/ctrl_out_capture_pkg.sv
// Shared types and sizing for the AD9361 CTRL_OUT event capture block.
// CTRL_OUT_CAPTURE_TS_EN selects whether queued entries carry a timestamp.
package ctrl_out_capture_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned SRC_W = 2;
   localparam int unsigned VAL_W = 16;

`ifdef CTRL_OUT_CAPTURE_TS_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   // Stored entry width: {src, status_1, status_0[, ts]}
   function automatic int unsigned entry_width(input int unsigned ts_width);
      return SRC_W + VAL_W + (TS_EN ? ts_width : 32'd0);
   endfunction

endpackage

// File: rtl/ctrl_out_capture_fifo.sv
// Synchronous show-ahead FIFO; pointers carry an extra MSB to tell full from empty.
module ctrl_out_capture_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 18
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             pop_ok;
   logic             push_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // A push into a full FIFO is legal only when the head leaves in the same cycle
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/ctrl_out_event_capture.sv
// Queues masked CTRL_OUT transitions from two AD9361s for the PS to drain via EMIO GPIO.
// Define CTRL_OUT_CAPTURE_TS_EN to build the free-running timestamp into each entry.
module ctrl_out_event_capture
   import ctrl_out_capture_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned TS_WIDTH   = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [7:0]                    status_0_i,
   input  logic [7:0]                    status_1_i,
   input  logic                          enable_i,
   input  logic [7:0]                    mask_0_i,
   input  logic [7:0]                    mask_1_i,
   input  logic                          rd_toggle_i,
   input  logic                          ovf_clear_i,
   output logic                          evt_valid_o,
   output logic [1:0]                    evt_src_o,
   output logic [15:0]                   evt_value_o,
   output logic [TS_WIDTH-1:0]           evt_ts_o,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count_o,
   output logic                          overflow_o,
   output logic [7:0]                    drop_count_o
);

   localparam int unsigned ENTRY_W = entry_width(TS_WIDTH);

   logic [VAL_W-1:0]   meta_q;
   logic [VAL_W-1:0]   sync_q;
   logic [VAL_W-1:0]   prev_q;
   logic               rd_in_q;
   logic               rd_toggle_q;
   state_e             state_q;
   state_e             state_d;
   logic               init_cnt_q;
   logic               init_cnt_d;
   logic [7:0]         chg0_c;
   logic [7:0]         chg1_c;
   logic               fire_c;
   logic               pop_c;
   logic               push_c;
   logic               drop_c;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] wdata;
   logic [ENTRY_W-1:0] rdata;
   logic               overflow_q;
   logic [7:0]         drop_count_q;

   // Two-flop synchronizer plus one-cycle history for edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q      <= '0;
         sync_q      <= '0;
         prev_q      <= '0;
         rd_in_q     <= 1'b0;
         rd_toggle_q <= 1'b0;
      end else begin
         meta_q      <= {status_1_i, status_0_i};
         sync_q      <= meta_q;
         prev_q      <= sync_q;
         rd_in_q     <= rd_toggle_i;
         rd_toggle_q <= rd_in_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= INIT;
         init_cnt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      fire_c     = 1'b0;
      chg0_c     = (sync_q[7:0]  ^ prev_q[7:0])  & mask_0_i;
      chg1_c     = (sync_q[15:8] ^ prev_q[15:8]) & mask_1_i;
      case (state_q)
         INIT: begin
            init_cnt_d = 1'b1;
            if (init_cnt_q) state_d = RUN;
         end
         RUN:     fire_c = enable_i && ((|chg0_c) || (|chg1_c));
         default: state_d = INIT;
      endcase
   end

   assign pop_c  = (rd_in_q ^ rd_toggle_q) && !fifo_empty;
   assign push_c = fire_c && (!fifo_full || pop_c);
   assign drop_c = fire_c && fifo_full && !pop_c;

   // A drop in the same cycle as a clear restarts the count at one
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else if (drop_c) begin
         overflow_q   <= 1'b1;
         if (ovf_clear_i)                drop_count_q <= 8'd1;
         else if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      end else if (ovf_clear_i) begin
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end
   end

`ifdef CTRL_OUT_CAPTURE_TS_EN
   logic [TS_WIDTH-1:0] ts_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) ts_q <= '0;
      else       ts_q <= ts_q + TS_WIDTH'(1);
   end

   assign wdata       = {(|chg1_c), (|chg0_c), sync_q, ts_q};
   assign evt_ts_o    = fifo_empty ? '0 : rdata[TS_WIDTH-1:0];
   assign evt_value_o = fifo_empty ? '0 : rdata[TS_WIDTH +: VAL_W];
   assign evt_src_o   = fifo_empty ? '0 : rdata[TS_WIDTH+VAL_W +: SRC_W];
`else
   assign wdata       = {(|chg1_c), (|chg0_c), sync_q};
   assign evt_ts_o    = '0;
   assign evt_value_o = fifo_empty ? '0 : rdata[0 +: VAL_W];
   assign evt_src_o   = fifo_empty ? '0 : rdata[VAL_W +: SRC_W];
`endif

   ctrl_out_capture_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push_c),
      .wdata_i (wdata),
      .pop_i   (pop_c),
      .rdata_o (rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (evt_count_o)
   );

   assign evt_valid_o  = !fifo_empty;
   assign overflow_o   = overflow_q;
   assign drop_count_o = drop_count_q;

endmodule

// File: doc/ctrl_out_event_capture.md
# ctrl_out_event_capture

Captures transitions on the two AD9361 CTRL_OUT buses (gpio_status_0/1) and queues them, with a free-running timestamp, for the PS to drain over EMIO GPIO. It is the inbound counterpart to the GPIO-driven line matrix: that block pushes PS-configured state out to the accessory, and this block reports RFIC-side state changes back to the PS. It sits in system_top between the gpio_status pins and the gpio_i bits.

## Interface
- FIFO_DEPTH, 16: entries; must be a power of two, minimum 2.
- TS_WIDTH, 16: timestamp width in clk cycles.
- clk  in  1  fabric clock.
- rst  in  1  synchronous reset, active-high.
- status_0  in  8  CTRL_OUT of AD9361 #0; asynchronous to clk.
- status_1  in  8  CTRL_OUT of AD9361 #1; asynchronous to clk.
- enable  in  1  when low, no events are queued.
- mask_0, mask_1  in  8 each  per-bit change-detect enables.
- rd_toggle  in  1  level driven from GPIO; each transition pops one entry.
- ovf_clear  in  1  level; while high, clears overflow and drop_count.
- evt_valid  out  1  FIFO not empty.
- evt_src  out  2  head entry: bit0 = bus 0 changed, bit1 = bus 1 changed.
- evt_value  out  16  head entry: {status_1, status_0} after synchronization.
- evt_ts  out  TS_WIDTH  head entry timestamp.
- evt_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag; set when an event was dropped.
- drop_count  out  8  saturating count of dropped events.

## Operation
- Each status bus passes through a 2-flop synchronizer. The synchronized value s is compared against prev, which is updated every cycle.
- chg0 = (s0 ^ prev0) & mask_0 and chg1 = (s1 ^ prev1) & mask_1. An event fires when (|chg0 | |chg1) and enable and state is RUN.
- Entry layout: {src[1:0], s1, s0, ts}. Both buses share one entry, so at most one push occurs per cycle and no arbitration is needed.
- ts is a free-running wrapping counter that starts at 0 on reset. An entry carries the ts value of the cycle in which it was detected.
- State machine:
  - INIT lasts 2 cycles after reset. The synchronizer and prev fill during INIT; no events fire.
  - RUN is entered after INIT and is left only on rst.
- prev keeps tracking while enable is low, so re-enabling never produces a stale event.
- Pop: rd_toggle_q registers rd_toggle. When rd_toggle != rd_toggle_q, one entry is popped. A pop while the FIFO is empty is ignored.
- Full: if the FIFO is full and no pop occurs in the same cycle, the event is dropped, overflow is set, and drop_count increments, saturating at 255.
- Push and pop in the same cycle:
  - Both take effect and occupancy is unchanged.
  - When full, this counts as no overflow.
  - When empty, the push is accepted and the pop is ignored.
- ovf_clear and a drop in the same cycle: the drop wins, leaving overflow = 1 and drop_count = 1.
- evt_* outputs show the head entry (show-ahead). They are undefined-but-stable when evt_valid = 0, and the implementation drives them to 0.

## Timing
- Reset values: evt_valid 0, evt_src 0, evt_value 0, evt_ts 0, evt_count 0, overflow 0, drop_count 0. Internally ts = 0, pointers = 0, sync/prev = 0, state INIT.
- Latency from a pin change sampled at edge E0:
  - sync stage2 holds the new value after E1;
  - the push occurs at E2;
  - evt_valid is high after E2, i.e. 3 edges in total.
- Pop latency: a rd_toggle change registered at edge P0 is detected combinationally; the pop occurs at edge P1, and the head and evt_count update after P1.
- Throughput: one push and one pop per cycle.
- Reset mid-operation: all queued entries are discarded, the block re-enters INIT, and the first event is possible 3 cycles after rst deasserts.

## Configuration
- CTRL_OUT_CAPTURE_TS_EN defined: the timestamp counter is built and entries store ts.
- CTRL_OUT_CAPTURE_TS_EN undefined:
  - no ts counter or ts storage is built;
  - evt_ts is tied to 0;
  - entry width drops to 18 bits;
  - all other behaviour is identical.

## Structure
- Package ctrl_out_capture_pkg holds:
  - the state enum {INIT, RUN};
  - SRC_W = 2 and VAL_W = 16;
  - the entry-width function of TS_WIDTH and the macro.
- Sub-module ctrl_out_capture_fifo is a synchronous show-ahead FIFO with push/pop/full/empty/count and ptr-wrap by an extra MSB. The top level owns the synchronizers, change detect, state machine, toggle-edge logic, overflow, and the timestamp.

## Test plan
- Reset, hold 5 cycles, then status_0 0x00 -> 0x04 with masks 0xFF: evt_valid rises 3 edges after the change, with evt_src = 01, evt_value = 0x0004, and evt_count = 1.
- status_0 and status_1 change in the same cycle (0x01, 0x80): a single entry is produced with src = 11, value = 0x8001, and evt_count = 1.
- mask_1 = 0x00 and status_1 toggles: no event. Then enable = 0 while status_0 changes, followed by enable = 1: still no event.
- Push 16 events and then a 17th with no pop: overflow = 1, drop_count = 1, evt_count = 16. Next, the 18th event arrives together with an rd_toggle edge: it is accepted, evt_count stays 16, and drop_count stays 1.
- Toggle rd_toggle 3 times with 2 entries queued: 2 pops occur in FIFO order, the 3rd is ignored, evt_count = 0, and evt_valid = 0.
- Assert ovf_clear in the same cycle as a drop: overflow = 1 and drop_count = 1. Assert rst with 5 entries queued: evt_count = 0 and no event occurs during the following 2 INIT cycles.
